onehot_scan_decoder: RTL and testbench

//  Parametrised, registered binary-to-one-hot decoder with three modes: off, manual select
//  (valid/ready load) and auto-scan (rotating one-hot with programmable dwell).

---
 rtl/decoder_pkg.sv | 17 +
 rtl/onehot_decode.sv | 15 +
 rtl/onehot_scan_decoder.sv | 133 +++++++++++++
 tb/tb_onehot_scan_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared encodings for the one-hot scan decoder: MODE input values and controller states.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_MAN  = 2'b01,
        MODE_SCAN = 2'b10,
        MODE_RSV  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_MAN  = 2'b01,
        S_SCAN = 2'b10
    } state_t;

endpackage

// File: rtl/onehot_decode.sv
// Combinational index to one-hot decoder; exactly one output bit set for any index.
module onehot_decode #(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] idx,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with off / manual-load / auto-scan modes.
// Optional SCAN_MASK_EN build adds a SCAN_MASK input restricting which indices the scan visits.
module onehot_scan_decoder #(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 8,
    localparam int OUT_W   = 1 << SEL_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [1:0]         MODE,
    input  logic [SEL_W-1:0]   SEL,
    input  logic               SEL_VALID,
    output logic               SEL_READY,
    input  logic [DWELL_W-1:0] DWELL,
`ifdef SCAN_MASK_EN
    input  logic [OUT_W-1:0]   SCAN_MASK,
`endif
    output logic [OUT_W-1:0]   FINAL_OUT,
    output logic [SEL_W-1:0]   CUR_SEL,
    output logic               WRAP
);
    import decoder_pkg::*;

    state_t             state;
    state_t             next_state;
    logic [DWELL_W-1:0] cnt;
    logic [SEL_W-1:0]   cur_sel;
    logic [SEL_W-1:0]   scan_next;
    logic [SEL_W-1:0]   dec_idx;
    logic [OUT_W-1:0]   final_out;
    logic [OUT_W-1:0]   dec_out;
    logic               wrap;
    logic               take;
    logic               dwell_done;
    logic               scan_live;

`ifdef SCAN_MASK_EN
    // Next enabled index strictly after cur, wrapping; returns cur itself if it is the only one.
    function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] cur,
                                                      input logic [OUT_W-1:0] mask);
        logic [SEL_W-1:0] res;
        logic [SEL_W-1:0] cand;
        logic             found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= OUT_W; i++) begin
            cand = cur + SEL_W'(i);
            if (!found && mask[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign scan_live = |SCAN_MASK;
    assign scan_next = next_enabled(cur_sel, SCAN_MASK);
`else
    assign scan_live = 1'b1;
    assign scan_next = cur_sel + SEL_W'(1);
`endif

    assign take       = (state == S_MAN) && SEL_VALID;
    assign dwell_done = (cnt >= DWELL);
    assign dec_idx    = take ? SEL : (((state == S_SCAN) && dwell_done) ? scan_next : cur_sel);

    onehot_decode #(.SEL_W(SEL_W)) u_decode (
        .idx    (dec_idx),
        .onehot (dec_out)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= S_OFF;
        else        state <= next_state;
    end

    always_comb begin
        next_state = S_OFF;
        case (mode_t'(MODE))
            MODE_MAN:  next_state = S_MAN;
            MODE_SCAN: next_state = S_SCAN;
            default:   next_state = S_OFF;
        endcase
    end

    always_comb begin
        SEL_READY = (state == S_MAN);
        FINAL_OUT = final_out;
        CUR_SEL   = cur_sel;
        WRAP      = wrap;
    end

    // A manual load always wins over scan entry so FINAL_OUT stays consistent with CUR_SEL.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cur_sel   <= '0;
            final_out <= '0;
            cnt       <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                S_MAN: begin
                    cnt <= '0;
                    if (take) begin
                        cur_sel   <= SEL;
                        final_out <= dec_out;
                    end else if (next_state == S_SCAN) begin
                        final_out <= scan_live ? dec_out : '0;
                    end
                end
                S_SCAN: begin
                    if (!scan_live) begin
                        final_out <= '0;
                        cnt       <= '0;
                    end else if (dwell_done) begin
                        cnt       <= '0;
                        cur_sel   <= scan_next;
                        final_out <= dec_out;
                        wrap      <= (scan_next <= cur_sel);
                    end else begin
                        cnt <= cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    cnt       <= '0;
                    final_out <= ((next_state == S_SCAN) && scan_live) ? dec_out : '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed table-driven bench for onehot_scan_decoder (SEL_W=3 instance plus a SEL_W=4 instance).
module tb_onehot_scan_decoder;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'b10;
    logic [2:0] sel = '0;
    logic       sel_valid = 1'b0;
    logic       sel_ready;
    logic [7:0] dwell = '0;
    logic [7:0] final_out;
    logic [2:0] cur_sel;
    logic       wrap;

    logic        rst16 = 1'b0;
    logic [1:0]  mode16 = 2'b00;
    logic [3:0]  sel16 = '0;
    logic        valid16 = 1'b0;
    logic        ready16;
    logic [7:0]  dwell16 = '0;
    logic [15:0] out16;
    logic [3:0]  cur16;
    logic        wrap16;

`ifdef SCAN_MASK_EN
    logic [7:0]  mask = 8'hFF;
    logic [15:0] mask16 = 16'hFFFF;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    onehot_scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut (
        .CLK       (CLK),
        .RST_N     (rst_n),
        .MODE      (mode),
        .SEL       (sel),
        .SEL_VALID (sel_valid),
        .SEL_READY (sel_ready),
        .DWELL     (dwell),
`ifdef SCAN_MASK_EN
        .SCAN_MASK (mask),
`endif
        .FINAL_OUT (final_out),
        .CUR_SEL   (cur_sel),
        .WRAP      (wrap)
    );

    onehot_scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut16 (
        .CLK       (CLK),
        .RST_N     (rst16),
        .MODE      (mode16),
        .SEL       (sel16),
        .SEL_VALID (valid16),
        .SEL_READY (ready16),
        .DWELL     (dwell16),
`ifdef SCAN_MASK_EN
        .SCAN_MASK (mask16),
`endif
        .FINAL_OUT (out16),
        .CUR_SEL   (cur16),
        .WRAP      (wrap16)
    );

    typedef struct {
        logic       rst_n;
        logic [1:0] mode;
        logic [2:0] sel;
        logic       vld;
        logic [7:0] dwell;
        logic [7:0] e_out;
        logic [2:0] e_sel;
        logic       e_rdy;
        logic       e_wrap;
    } vec_t;

    vec_t vecs[31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] e_out, input logic [2:0] e_sel,
                        input logic e_rdy, input logic e_wrap);
        chk({tag, ".final_out"}, 32'(final_out), 32'(e_out));
        chk({tag, ".cur_sel"},   32'(cur_sel),   32'(e_sel));
        chk({tag, ".sel_ready"}, 32'(sel_ready), 32'(e_rdy));
        chk({tag, ".wrap"},      32'(wrap),      32'(e_wrap));
    endtask

    initial begin
        // reset with MODE=SCAN held
        vecs[0]  = '{1'b0, 2'b10, 3'd0, 1'b0, 8'd0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 2'b10, 3'd0, 1'b0, 8'd0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'b10, 3'd0, 1'b0, 8'd0, 8'h00, 3'd0, 1'b0, 1'b0};
        // manual load of 5, then SEL_VALID ignored while off
        vecs[3]  = '{1'b1, 2'b01, 3'd5, 1'b0, 8'd0, 8'h00, 3'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 3'd5, 1'b1, 8'd0, 8'h20, 3'd5, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'b00, 3'd5, 1'b0, 8'd0, 8'h20, 3'd5, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'b00, 3'd3, 1'b1, 8'd0, 8'h00, 3'd5, 1'b0, 1'b0};
        // scan from 5 with DWELL=2: three cycles per index, wrap 7->0
        vecs[7]  = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd2, 8'h20, 3'd5, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd2, 8'h20, 3'd5, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd2, 8'h20, 3'd5, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd2, 8'h40, 3'd6, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd2, 8'h40, 3'd6, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd2, 8'h40, 3'd6, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd2, 8'h80, 3'd7, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd2, 8'h80, 3'd7, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd2, 8'h80, 3'd7, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd2, 8'h01, 3'd0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd2, 8'h01, 3'd0, 1'b0, 1'b0};
        // DWELL=0: advance every cycle
        vecs[18] = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd0, 8'h02, 3'd1, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd0, 8'h04, 3'd2, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 2'b10, 3'd3, 1'b0, 8'd0, 8'h08, 3'd3, 1'b0, 1'b0};
        // scan -> manual freezes; manual -> off clears FINAL_OUT, CUR_SEL kept
        vecs[21] = '{1'b1, 2'b01, 3'd0, 1'b0, 8'd0, 8'h10, 3'd4, 1'b1, 1'b0};
        vecs[22] = '{1'b1, 2'b01, 3'd0, 1'b0, 8'd0, 8'h10, 3'd4, 1'b1, 1'b0};
        vecs[23] = '{1'b1, 2'b01, 3'd0, 1'b0, 8'd0, 8'h10, 3'd4, 1'b1, 1'b0};
        vecs[24] = '{1'b1, 2'b00, 3'd0, 1'b0, 8'd0, 8'h10, 3'd4, 1'b0, 1'b0};
        vecs[25] = '{1'b1, 2'b00, 3'd0, 1'b0, 8'd0, 8'h00, 3'd4, 1'b0, 1'b0};
        // reset in the middle of a dwell
        vecs[26] = '{1'b1, 2'b10, 3'd0, 1'b0, 8'd5, 8'h10, 3'd4, 1'b0, 1'b0};
        vecs[27] = '{1'b1, 2'b10, 3'd0, 1'b0, 8'd5, 8'h10, 3'd4, 1'b0, 1'b0};
        vecs[28] = '{1'b1, 2'b10, 3'd0, 1'b0, 8'd5, 8'h10, 3'd4, 1'b0, 1'b0};
        vecs[29] = '{1'b0, 2'b10, 3'd0, 1'b0, 8'd5, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[30] = '{1'b1, 2'b00, 3'd0, 1'b0, 8'd5, 8'h00, 3'd0, 1'b0, 1'b0};

        for (int i = 0; i < 31; i++) begin
            rst_n     = vecs[i].rst_n;
            mode      = vecs[i].mode;
            sel       = vecs[i].sel;
            sel_valid = vecs[i].vld;
            dwell     = vecs[i].dwell;
            tick();
            chk8($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_sel, vecs[i].e_rdy, vecs[i].e_wrap);
        end

        // lowering DWELL below the running count forces an advance on the next edge
        mode  = 2'b10;
        dwell = 8'd5;
        tick();
        chk8("dwl_entry", 8'h01, 3'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk8("dwl_hold", 8'h01, 3'd0, 1'b0, 1'b0);
        dwell = 8'd1;
        tick();
        chk8("dwl_force", 8'h02, 3'd1, 1'b0, 1'b0);
        tick();
        chk8("dwl_cnt1", 8'h02, 3'd1, 1'b0, 1'b0);
        tick();
        chk8("dwl_next", 8'h04, 3'd2, 1'b0, 1'b0);

`ifdef SCAN_MASK_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mask  = 8'b1000_0101;
        dwell = 8'd0;
        tick();
        chk8("msk_entry", 8'h01, 3'd0, 1'b0, 1'b0);
        tick();
        chk8("msk_2", 8'h04, 3'd2, 1'b0, 1'b0);
        tick();
        chk8("msk_7", 8'h80, 3'd7, 1'b0, 1'b0);
        tick();
        chk8("msk_wrap", 8'h01, 3'd0, 1'b0, 1'b1);
        mask = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk8($sformatf("msk_zero%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
        end
        mask = 8'hFF;
`endif

        // SEL_W=4 instance: manual 15, then scan wraps 15 -> 0
        tick();
        rst16  = 1'b1;
        mode16 = 2'b01;
        tick();
        chk("w16_ready", 32'(ready16), 32'd1);
        sel16   = 4'd15;
        valid16 = 1'b1;
        tick();
        chk("w16_out15", 32'(out16), 32'h8000);
        chk("w16_sel15", 32'(cur16), 32'd15);
        valid16 = 1'b0;
        mode16  = 2'b10;
        dwell16 = 8'd0;
        tick();
        chk("w16_entry", 32'(out16), 32'h8000);
        tick();
        chk("w16_wrap_out", 32'(out16), 32'h0001);
        chk("w16_wrap_sel", 32'(cur16), 32'd0);
        chk("w16_wrap", 32'(wrap16), 32'd1);
        tick();
        chk("w16_next_sel", 32'(cur16), 32'd1);
        chk("w16_wrap_low", 32'(wrap16), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
